fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Fetch-side producer of the instruction/PC_inc pair consumed by the decode stage.
- Owns the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Buffers returned instructions in a small FIFO and presents the head to decode under a valid/stall handshake.
- Handles branch/jump redirect flushes, HALT detection and misaligned-fetch error reporting.

Parameters:
DEPTH, 2, number of instruction-queue entries; power of two, at least 2
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INST, 16'h0800, instruction driven to decode when the queue is empty

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset; 0 = reset asserted
redirect  in  1  branch/jump resolved taken; flush and refetch
redirect_pc  in  16  target PC for redirect
stall_ID  in  1  decode cannot accept the head this cycle
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  16  fetch address; valid while imem_req=1
imem_data  in  16  returned instruction; valid when imem_done=1
imem_done  in  1  response strobe; at least 1 cycle after imem_req
inst  out  16  queue head instruction, or NOP_INST when empty
PC_inc  out  16  address of head instruction + 2
inst_valid  out  1  head entry present
err  out  1  sticky misaligned-fetch error

Behaviour:
- Reset (rst=0, asynchronous):
  - PC=RESET_PC, queue count=0, FSM=IDLE, err=0.
  - Outputs: imem_req=0, inst_valid=0, inst=NOP_INST, PC_inc=16'h0000, imem_addr=RESET_PC.
  - An in-flight memory response arriving after reset release is ignored because the FSM is in IDLE.
- FSM states: IDLE, WAIT, DROP, HALTED.
- IDLE:
  - If count < DEPTH and redirect=0: assert imem_req, drive imem_addr=PC, go to WAIT.
  - Otherwise imem_req=0.
- WAIT, imem_done=1 and redirect=0:
  - Enqueue {imem_data, PC+2}; PC <= PC+2.
  - If imem_data[15:11]==5'b00000 (HALT): go to HALTED; otherwise go to IDLE.
- WAIT, redirect=1:
  - PC <= redirect_pc; flush the queue.
  - If imem_done=1 in the same cycle: discard the response and go to IDLE. Otherwise go to DROP.
- DROP:
  - Wait for imem_done; discard the data; go to IDLE.
  - A redirect while in DROP updates PC and stays in DROP.
- HALTED:
  - No requests are issued. The queue still drains to decode.
  - Only redirect or reset leaves HALTED (redirect to IDLE).
- Dequeue: when inst_valid=1 and stall_ID=0, pop the head at the clock edge. The next head, or NOP, appears the following cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Full condition: no request is issued while count==DEPTH. An enqueue into a full queue cannot occur, because requests are gated on space.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- PC arithmetic is modulo 2^16; PC 16'hFFFE increments to 16'h0000.
- Redirect priority: redirect overrides any same-cycle enqueue or dequeue.
  - Queue is empty next cycle, inst_valid=0.
  - A request may issue the cycle after the redirect, from IDLE.
- err: set when a request issues with imem_addr[0]=1. It stays set until reset. The fetch itself still proceeds.
- Latency: with 1-cycle memory, the first inst_valid comes 2 cycles after the request (request cycle, done cycle, then visible). Sustained throughput is 1 instruction per 2 cycles.
- inst, PC_inc and inst_valid are registered from queue storage, with no combinational path from imem_data.

Test Plan:
- Reset release, 1-cycle memory returning 16'h4123, 16'h4224, stall_ID=0:
  - imem_addr sequence 0x0000, 0x0002.
  - inst=16'h4123 with PC_inc=16'h0002, then 16'h4224 with PC_inc=16'h0004.
  - inst_valid low between entries.
- stall_ID held high for 10 cycles, DEPTH=2:
  - Exactly 2 requests issue, then imem_req stays 0.
  - Releasing the stall drains both entries in order, then fetching resumes at PC 0x0004.
- Redirect to 0x0100 while in WAIT, with imem_done 3 cycles later:
  - That response is dropped and the queue is flushed.
  - The next imem_addr is 0x0100, and no stale instruction reaches inst.
- Memory returns 16'h0000 (HALT) at PC 0x0006:
  - HALT is delivered with PC_inc 0x0008, then no further imem_req.
  - Redirect to 0x0020 resumes fetching at 0x0020.
- Redirect to 0x0011: err rises after the request at 0x0011 and stays 1 until rst is pulsed low.
- rst asserted low while in WAIT with 2 queued entries:
  - All outputs return to reset values immediately (asynchronously).
  - A late imem_done is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch unit: owns the PC, issues single-outstanding requests to instruction memory and
// queues returned instructions for decode under a valid/stall handshake.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall_ID,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] inst,
  output logic [15:0] PC_inc,
  output logic        inst_valid,
  output logic        err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return (word[15:11] == 5'b00000);
  endfunction

  state_t          state_r, state_s;
  logic [15:0]     pc_r, pc_s;
  logic            req_s, enq_s, deq_s;
  logic [PW-1:0]   wr_ptr_r, wr_s, rd_ptr_r, rd_s;
  logic [CW-1:0]   count_r, count_s;
  logic [15:0]     mem_inst_r [DEPTH];
  logic [15:0]     mem_pc_r   [DEPTH];
  logic [15:0]     head_inst_s, head_pc_s;
  logic [15:0]     inst_r, pc_inc_r;
  logic            inst_valid_r, err_r;

  assign imem_req   = req_s & rst;
  assign imem_addr  = pc_r;
  assign inst       = inst_r;
  assign PC_inc     = pc_inc_r;
  assign inst_valid = inst_valid_r;
  assign err        = err_r;

  // Next-state, request and PC update; redirect always wins over enqueue
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    req_s   = 1'b0;
    enq_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          pc_s = redirect_pc;
        end else if (count_r < CW'(DEPTH)) begin
          req_s   = 1'b1;
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_s    = redirect_pc;
          state_s = imem_done ? IDLE : DROP;
        end else if (imem_done) begin
          enq_s   = 1'b1;
          pc_s    = pc_r + 16'd2;
          state_s = is_halt(imem_data) ? HALTED : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_s = redirect_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem_done) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_s    = redirect_pc;
          state_s = IDLE;
        end else begin
          state_s = HALTED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Queue pointer/count update; a redirect empties the queue
  always_comb begin
    deq_s   = inst_valid_r & ~stall_ID & ~redirect;
    rd_s    = rd_ptr_r;
    wr_s    = wr_ptr_r;
    count_s = count_r;
    if (redirect) begin
      rd_s    = PW'(0);
      wr_s    = PW'(0);
      count_s = CW'(0);
    end else begin
      rd_s = deq_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
      wr_s = enq_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
      if (enq_s && !deq_s) begin
        count_s = count_r + CW'(1);
      end else if (!enq_s && deq_s) begin
        count_s = count_r - CW'(1);
      end else begin
        count_s = count_r;
      end
    end
  end

  // Head seen by decode next cycle; a fresh entry landing at the head bypasses storage
  always_comb begin
    head_inst_s = NOP_INST;
    head_pc_s   = 16'h0000;
    if (count_s == CW'(0)) begin
      head_inst_s = NOP_INST;
    end else if (enq_s && (rd_s == wr_ptr_r)) begin
      head_inst_s = imem_data;
      head_pc_s   = pc_r + 16'd2;
    end else begin
      head_inst_s = mem_inst_r[rd_s];
      head_pc_s   = mem_pc_r[rd_s];
    end
  end

  // Control state, PC, pointers and sticky misalignment flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      wr_ptr_r <= wr_s;
      rd_ptr_r <= rd_s;
      count_r  <= count_s;
      err_r    <= err_r | (imem_req & pc_r[0]);
    end
  end

  // Queue storage write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_r[i] <= NOP_INST;
        mem_pc_r[i]   <= 16'h0000;
      end
    end else if (enq_s) begin
      mem_inst_r[wr_ptr_r] <= imem_data;
      mem_pc_r[wr_ptr_r]   <= pc_r + 16'd2;
    end else begin
      mem_inst_r[wr_ptr_r] <= mem_inst_r[wr_ptr_r];
      mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
    end
  end

  // Registered decode-facing outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_r       <= NOP_INST;
      pc_inc_r     <= 16'h0000;
      inst_valid_r <= 1'b0;
    end else begin
      inst_r       <= head_inst_s;
      pc_inc_r     <= head_pc_s;
      inst_valid_r <= (count_s != CW'(0));
    end
  end

endmodule
